noc_node_injector: RTL and testbench
====================================

NOC_NODE_INJECTOR -- requirements
Module: noc_node_injector

Interface
REQ-001 SHALL have parameter NOC_WIDTH, default 600, meaning NoC port flit width in bits.
REQ-002 SHALL have parameter NOC_NODES, default 16, meaning node count; DEST_W = clog2(NOC_NODES).
REQ-003 SHALL have parameter FLITS, default 4, meaning flits per packet, legal range 1..16.
REQ-004 SHALL have parameter CREDITS, default 8, meaning downstream buffer depth in flits, legal range 1..15.
REQ-005 SHALL derive PAYLOAD_W = NOC_WIDTH-3-DEST_W (593 at defaults).
REQ-006 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port in_valid  input  1  client packet valid.
REQ-009 SHALL have port in_ready  output  1  injector can accept a packet.
REQ-010 SHALL have port in_dest  input  DEST_W  destination node id.
REQ-011 SHALL have port in_data  input  FLITS*PAYLOAD_W  packet payload.
REQ-012 SHALL have port flit_out  output  NOC_WIDTH  registered flit to the NoC router input.
REQ-013 SHALL have port credit_in  input  1  one-cycle pulse returning one downstream buffer slot.
REQ-014 SHALL have port pkt_count  output  16  packets fully sent; wraps 0xFFFF->0.
REQ-015 SHALL have port err_credit  output  1  sticky credit-overflow flag.

Function
REQ-016 SHALL use flit layout: bit NOC_WIDTH-1 valid, NOC_WIDTH-2 head, NOC_WIDTH-3 tail, [NOC_WIDTH-4 -: DEST_W] dest, [PAYLOAD_W-1:0] payload.
REQ-017 SHALL have states IDLE and SEND; in_ready = 1 exactly when state is IDLE.
REQ-018 SHALL accept a packet on a rising edge with in_valid=1 and in_ready=1, latching in_dest and in_data, clearing flit index to 0, and entering SEND.
REQ-019 SHALL, in SEND, issue a flit on a cycle only if the registered credit count is >0; credit_in in the same cycle does not enable issue.
REQ-020 SHALL make flit k carry in_data[k*PAYLOAD_W +: PAYLOAD_W], flits in order k=0..FLITS-1, latched dest in every flit.
REQ-021 SHALL set head=1 only on flit 0 and tail=1 only on flit FLITS-1; FLITS=1 gives head=tail=1 on one flit.
REQ-022 SHALL present an issued flit on flit_out after the edge on which issue is decided; first flit appears one cycle after acceptance when credits are available.
REQ-023 SHALL drive flit_out to all zeros on every cycle without an issued flit.
REQ-024 SHALL return to IDLE on the edge that issues flit FLITS-1, and increment pkt_count on that edge.
REQ-025 SHALL not accept a packet in the cycle the tail is issued; back-to-back packets have a one-cycle gap (throughput FLITS/(FLITS+1)).
REQ-026 SHALL update the credit counter: issue only -> -1; credit_in only -> +1; both -> unchanged; neither -> unchanged.
REQ-027 SHALL ignore credit_in when count==CREDITS and no flit issues that cycle, keep count at CREDITS, and set err_credit=1 until reset.
REQ-028 SHALL stall in SEND with flit index held and flit_out zero while credit count is 0.

Reset
REQ-029 SHALL, while rst=0, asynchronously force state IDLE, flit index 0, credit count CREDITS, flit_out 0, pkt_count 0, err_credit 0, latched dest/data 0.
REQ-030 SHALL abandon any partially sent packet on reset mid-packet; no further flits of it are issued.
REQ-031 SHALL drive in_ready=1 after reset deassertion (IDLE); no acceptance occurs while rst=0.

Verification
REQ-032 SHALL cover: defaults, one packet dest=5, CREDITS full -> four consecutive flits on cycles T+1..T+4, head on first, tail on fourth, dest=5, payload slices in order, pkt_count=1.
REQ-033 SHALL cover: CREDITS=2, no credit_in -> two flits issue, then flit_out=0 and stall; one credit_in pulse -> flit 2 issues two cycles later.
REQ-034 SHALL cover: credit_in pulsed on the same cycle as each issue -> credit count stays at 8 throughout the packet.
REQ-035 SHALL cover: credit_in at count=8 while idle -> count remains 8, err_credit=1 until rst.
REQ-036 SHALL cover: rst low after flit 1 of a packet -> flit_out=0 immediately, credits=8, in_ready=1 after release, new packet starts with head flit.
REQ-037 SHALL cover: FLITS=1, in_valid held high -> single head+tail flit every other cycle, pkt_count increments per packet.

Source files
------------

// File: rtl/noc_node_injector.sv
// Packet-to-flit injector: latches one client packet, serialises it into
// head/body/tail flits and paces issue against a downstream credit counter.
module noc_node_injector #(
  parameter int NOC_WIDTH = 600,
  parameter int NOC_NODES = 16,
  parameter int FLITS     = 4,
  parameter int CREDITS   = 8,
  localparam int DEST_W    = $clog2(NOC_NODES),
  localparam int PAYLOAD_W = NOC_WIDTH - 3 - DEST_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DEST_W-1:0]          in_dest,
  input  logic [FLITS*PAYLOAD_W-1:0] in_data,
  output logic [NOC_WIDTH-1:0]       flit_out,
  input  logic                       credit_in,
  output logic [15:0]                pkt_count,
  output logic                       err_credit
);

  localparam int IDX_W = (FLITS > 1) ? $clog2(FLITS) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FLITS - 1);
  localparam logic [3:0] CRED_MAX = 4'(CREDITS);

  logic [0:0]               state;
  logic [IDX_W-1:0]         idx;
  logic [3:0]               credits;
  logic [DEST_W-1:0]        dest_q;
  logic [FLITS*PAYLOAD_W-1:0] data_q;
  logic                     issue;
  logic                     last;
  logic [PAYLOAD_W-1:0]     slice;

  assign in_ready = (state == IDLE);
  // Issue depends only on the registered count, so a same-cycle credit cannot unblock it.
  assign issue    = (state == SEND) && (credits != 4'd0);
  assign last     = (idx == LAST_IDX);

  always_comb begin
    slice = '0;
    for (int unsigned k = 0; k < FLITS; k++) begin
      if (idx == IDX_W'(k)) slice = data_q[k*PAYLOAD_W +: PAYLOAD_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      credits    <= CRED_MAX;
      flit_out   <= '0;
      pkt_count  <= '0;
      err_credit <= 1'b0;
      dest_q     <= '0;
      data_q     <= '0;
    end else begin
      flit_out <= '0;
      if (issue) flit_out <= {1'b1, (idx == '0), last, dest_q, slice};

      // A returned credit with the counter already full is an upstream protocol error.
      case ({issue, credit_in})
        2'b10:   credits <= credits - 4'd1;
        2'b01: begin
          if (credits == CRED_MAX) err_credit <= 1'b1;
          else                     credits    <= credits + 4'd1;
        end
        default: ;
      endcase

      if (state == IDLE) begin
        if (in_valid) begin
          dest_q <= in_dest;
          data_q <= in_data;
          idx    <= '0;
          state  <= SEND;
        end
      end else if (issue) begin
        if (last) begin
          state     <= IDLE;
          pkt_count <= pkt_count + 16'd1;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_noc_node_injector.sv
// Bench for noc_node_injector: a default-size instance checked against a flit-queue
// model, plus small instances for credit starvation and single-flit packets.
module tb_noc_node_injector;

  localparam int W0 = 600, N0 = 16, F0 = 4, C0 = 8;
  localparam int D0 = $clog2(N0), P0 = W0 - 3 - D0;
  localparam int W1 = 32, D1 = 4, P1 = W1 - 3 - D1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic v0 = 0, r0, c0 = 0, e0;
  logic [D0-1:0] d0 = '0;
  logic [F0*P0-1:0] x0 = '0;
  logic [W0-1:0] f0;
  logic [15:0] p0;

  logic v1 = 0, r1, c1 = 0, e1;
  logic [D1-1:0] d1 = '0;
  logic [4*P1-1:0] x1 = '0;
  logic [W1-1:0] f1;
  logic [15:0] p1;

  logic v2 = 0, r2, c2 = 0, e2;
  logic [D1-1:0] d2 = '0;
  logic [P1-1:0] x2 = '0;
  logic [W1-1:0] f2;
  logic [15:0] p2;

  noc_node_injector #(.NOC_WIDTH(W0), .NOC_NODES(N0), .FLITS(F0), .CREDITS(C0)) u0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_dest(d0), .in_data(x0),
    .flit_out(f0), .credit_in(c0), .pkt_count(p0), .err_credit(e0));

  noc_node_injector #(.NOC_WIDTH(W1), .NOC_NODES(16), .FLITS(4), .CREDITS(2)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_dest(d1), .in_data(x1),
    .flit_out(f1), .credit_in(c1), .pkt_count(p1), .err_credit(e1));

  noc_node_injector #(.NOC_WIDTH(W1), .NOC_NODES(16), .FLITS(1), .CREDITS(8)) u2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .in_dest(d2), .in_data(x2),
    .flit_out(f2), .credit_in(c2), .pkt_count(p2), .err_credit(e2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W0-1:0] act, input logic [W0-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model for u0: the outstanding packet is a queue of whole flits,
  // released one per cycle while the credit balance is positive.
  logic [W0-1:0] mq[$];
  int            mcred;
  logic [15:0]   mpkt;
  logic          merr;

  function automatic logic [W0-1:0] mk0(input int k, input logic [D0-1:0] d, input logic [F0*P0-1:0] x);
    logic [W0-1:0] f;
    f = '0;
    f[W0-1] = 1'b1;
    f[W0-2] = (k == 0);
    f[W0-3] = (k == F0 - 1);
    f[W0-4 -: D0] = d;
    f[P0-1:0] = x[k*P0 +: P0];
    return f;
  endfunction

  function automatic logic [W1-1:0] mk1(input int k, input int nflits, input logic [D1-1:0] d, input logic [P1-1:0] pl);
    logic [W1-1:0] f;
    f = '0;
    f[W1-1] = 1'b1;
    f[W1-2] = (k == 0);
    f[W1-3] = (k == nflits - 1);
    f[W1-4 -: D1] = d;
    f[P1-1:0] = pl;
    return f;
  endfunction

  function automatic logic [F0*P0-1:0] rdata0();
    logic [F0*P0-1:0] r;
    for (int i = 0; i < F0*P0; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic step0(input logic v, input logic [D0-1:0] d, input logic [F0*P0-1:0] x,
                       input logic c, output logic [W0-1:0] got);
    logic [W0-1:0] expf;
    logic issue;
    v0 = v; d0 = d; x0 = x; c0 = c;
    #1;
    chk("u0_ready", W0'(r0), W0'(mq.size() == 0));
    expf = '0;
    issue = 1'b0;
    if (mq.size() == 0) begin
      if (v) for (int k = 0; k < F0; k++) mq.push_back(mk0(k, d, x));
    end else if (mcred > 0) begin
      expf = mq.pop_front();
      issue = 1'b1;
      if (expf[W0-3]) mpkt++;
    end
    if (issue && !c) mcred--;
    else if (c && !issue) begin
      if (mcred == C0) merr = 1'b1;
      else mcred++;
    end
    @(posedge clk); #1;
    chk("u0_flit", f0, expf);
    chk("u0_pkt", W0'(p0), W0'(mpkt));
    chk("u0_err", W0'(e0), W0'(merr));
    got = f0;
  endtask

  task automatic model_clear();
    mq.delete();
    mcred = C0;
    mpkt = '0;
    merr = 1'b0;
  endtask

  task automatic reset_all();
    rst = 1'b0;
    v0 = 0; c0 = 0; v1 = 0; c1 = 0; v2 = 0; c2 = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_u0_flit", f0, '0);
    chk("rst_u0_ready", W0'(r0), W0'(1));
    chk("rst_u0_pkt", W0'(p0), '0);
    chk("rst_u0_err", W0'(e0), '0);
    chk("rst_u1_flit", W0'(f1), '0);
    chk("rst_u2_ready", W0'(r2), W0'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rel_u0_ready", W0'(r0), W0'(1));
  endtask

  typedef struct {
    logic v;
    logic c;
    logic ready;
    int   fidx;
    logic err;
    int   pkt;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [W0-1:0] got;
    logic [F0*P0-1:0] pk;
    logic [W1-1:0] e1f;

    tbl[0]  = '{1, 0, 0, -1, 0, 0};
    tbl[1]  = '{0, 0, 0,  0, 0, 0};
    tbl[2]  = '{0, 0, 0,  1, 0, 0};
    tbl[3]  = '{0, 0, 0, -1, 0, 0};
    tbl[4]  = '{0, 1, 0, -1, 0, 0};
    tbl[5]  = '{0, 0, 0,  2, 0, 0};
    tbl[6]  = '{0, 0, 0, -1, 0, 0};
    tbl[7]  = '{0, 1, 0, -1, 0, 0};
    tbl[8]  = '{0, 0, 1,  3, 0, 1};
    tbl[9]  = '{0, 1, 1, -1, 0, 1};
    tbl[10] = '{0, 1, 1, -1, 0, 1};
    tbl[11] = '{0, 1, 1, -1, 1, 1};
    tbl[12] = '{0, 0, 1, -1, 1, 1};

    reset_all();

    // CREDITS=2 instance: starvation, single-credit resume, then overflow at full count.
    d1 = 4'd9;
    for (int i = 0; i < 4*P1; i++) x1[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < 13; i++) begin
      v1 = tbl[i].v;
      c1 = tbl[i].c;
      @(posedge clk); #1;
      e1f = (tbl[i].fidx < 0) ? '0 : mk1(tbl[i].fidx, 4, d1, x1[tbl[i].fidx*P1 +: P1]);
      chk($sformatf("u1_flit_row%0d", i), W0'(f1), W0'(e1f));
      chk($sformatf("u1_ready_row%0d", i), W0'(r1), W0'(tbl[i].ready));
      chk($sformatf("u1_err_row%0d", i), W0'(e1), W0'(tbl[i].err));
      chk($sformatf("u1_pkt_row%0d", i), W0'(p1), W0'(tbl[i].pkt));
    end
    v1 = 0; c1 = 0;

    // FLITS=1 instance with in_valid held: one head+tail flit every other cycle.
    v2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d2 = 4'(i + 1);
      x2 = P1'($urandom());
      @(posedge clk); #1;
      chk("u2_gap_flit", W0'(f2), '0);
      chk("u2_gap_ready", W0'(r2), '0);
      @(posedge clk); #1;
      chk("u2_flit", W0'(f2), W0'(mk1(0, 1, d2, x2)));
      chk("u2_ready", W0'(r2), W0'(1));
      chk("u2_pkt", W0'(p2), W0'(i + 1));
    end
    v2 = 1'b0;
    chk("u2_err", W0'(e2), '0);

    reset_all();

    // One packet to node 5 with full credits: four consecutive flits.
    pk = rdata0();
    step0(1, D0'(5), pk, 0, got);
    chk("p1_accept_flit", got, '0);
    for (int k = 0; k < F0; k++) begin
      step0(0, '0, '0, 0, got);
      chk($sformatf("p1_head_%0d", k), W0'(got[W0-2]), W0'(k == 0));
      chk($sformatf("p1_tail_%0d", k), W0'(got[W0-3]), W0'(k == F0 - 1));
      chk($sformatf("p1_dest_%0d", k), W0'(got[W0-4 -: D0]), W0'(5));
    end
    step0(0, '0, '0, 0, got);
    chk("p1_pkt_count", W0'(p0), W0'(1));

    reset_all();

    // Credit returned alongside every issue keeps the counter full, so an idle credit overflows.
    step0(1, D0'(7), rdata0(), 0, got);
    for (int k = 0; k < F0; k++) step0(0, '0, '0, 1, got);
    step0(0, '0, '0, 1, got);
    chk("ovf_err_set", W0'(e0), W0'(1));
    repeat (3) step0(0, '0, '0, 0, got);
    chk("ovf_err_sticky", W0'(e0), W0'(1));

    reset_all();

    // Reset in the middle of a packet.
    step0(1, D0'(2), rdata0(), 0, got);
    step0(0, '0, '0, 0, got);
    step0(0, '0, '0, 0, got);
    #2 rst = 1'b0;
    #1;
    chk("midrst_flit", f0, '0);
    chk("midrst_ready", W0'(r0), W0'(1));
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_rel_ready", W0'(r0), W0'(1));
    step0(1, D0'(3), rdata0(), 0, got);
    step0(0, '0, '0, 0, got);
    chk("midrst_new_head", W0'(got[W0-2]), W0'(1));
    chk("midrst_new_dest", W0'(got[W0-4 -: D0]), W0'(3));
    for (int k = 1; k < F0; k++) step0(0, '0, '0, 0, got);
    for (int k = 0; k < 4; k++) step0(0, '0, '0, 1, got);

    // Randomized traffic with random credit returns, including overflows.
    for (int n = 0; n < 400; n++) begin
      step0(1'($urandom_range(0, 1)), D0'($urandom_range(0, N0 - 1)), rdata0(),
            1'($urandom_range(0, 2) == 0), got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
